// File: rtl/y_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : y_pattern_gen_if
// Description : Y-component video stream bundle (sync, enable, luminance)
//               driven by the pattern generator and consumed by the
//               segmentation blocks.
// Revision    : 1.0 - initial release
// ============================================================================
interface y_pattern_gen_if;

  logic       Y_hsync;
  logic       Y_vsync;
  logic       Y_de;
  logic [7:0] Y_data;

  // Source side: the pattern generator drives the stream.
  modport master (
    output Y_hsync,
    output Y_vsync,
    output Y_de,
    output Y_data
  );

  // Sink side: threshold/filter stages observe the stream.
  modport slave (
    input Y_hsync,
    input Y_vsync,
    input Y_de,
    input Y_data
  );

endinterface
`default_nettype wire

// File: rtl/y_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : y_pattern_gen
// Description : Raster timing generator with selectable 8-bit luminance test
//               pattern (H-ramp, V-ramp, checker, flat). Produces the
//               Y_hsync/Y_vsync/Y_de/Y_data stream plus frame bookkeeping.
// Revision    : 1.0 - initial release
// ============================================================================
module y_pattern_gen #(
  parameter logic [11:0] H_DISP   = 12'd640,
  parameter logic [11:0] H_FRONT  = 12'd16,
  parameter logic [11:0] H_SYNC   = 12'd96,
  parameter logic [11:0] H_BACK   = 12'd48,
  parameter logic [11:0] V_DISP   = 12'd480,
  parameter logic [11:0] V_FRONT  = 12'd10,
  parameter logic [11:0] V_SYNC   = 12'd2,
  parameter logic [11:0] V_BACK   = 12'd33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         en,
  input  wire logic [1:0]   mode,
  input  wire logic [7:0]   flat_level,
  y_pattern_gen_if.master   y_out,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  // Region boundaries; each line/frame is active, front porch, sync, back porch.
  localparam logic [11:0] H_TOTAL    = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam logic [11:0] V_TOTAL    = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam logic [11:0] H_SS_START = H_DISP + H_FRONT;
  localparam logic [11:0] H_SS_END   = H_DISP + H_FRONT + H_SYNC;
  localparam logic [11:0] V_SS_START = V_DISP + V_FRONT;
  localparam logic [11:0] V_SS_END   = V_DISP + V_FRONT + V_SYNC;
  localparam logic [11:0] H_LAST     = H_TOTAL - 12'd1;
  localparam logic [11:0] V_LAST     = V_TOTAL - 12'd1;
  localparam logic [11:0] V_DISP_END = V_DISP - 12'd1;

  // IDLE parks the counters at the origin; DRAIN finishes the current frame
  // after the run request has been withdrawn.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q,      state_d;
  logic [11:0] h_cnt_q,      h_cnt_d;
  logic [11:0] v_cnt_q,      v_cnt_d;
  logic [1:0]  mode_q,       mode_d;
  logic        hsync_q,      hsync_d;
  logic        vsync_q,      vsync_d;
  logic        de_q,         de_d;
  logic [7:0]  data_q,       data_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_cnt_q,  frame_cnt_d;

  logic        running;
  logic        h_last;
  logic        frame_last;
  logic [11:0] h_adv;
  logic [11:0] v_adv;
  logic        de_c;
  logic        hs_c;
  logic        vs_c;
  logic [7:0]  pattern;

  // Raster position decode and the free-running counter step.
  always_comb begin
    running    = (state_q != ST_IDLE);
    h_last     = (h_cnt_q == H_LAST);
    frame_last = h_last && (v_cnt_q == V_LAST);
    de_c       = (h_cnt_q < H_DISP) && (v_cnt_q < V_DISP);
    hs_c       = (h_cnt_q >= H_SS_START) && (h_cnt_q < H_SS_END);
    // vsync depends on v_cnt only, so it spans whole lines aligned to h_cnt=0.
    vs_c       = (v_cnt_q >= V_SS_START) && (v_cnt_q < V_SS_END);
    h_adv      = h_last ? 12'd0 : (h_cnt_q + 12'd1);
    if (h_last) begin
      v_adv = (v_cnt_q == V_LAST) ? 12'd0 : (v_cnt_q + 12'd1);
    end else begin
      v_adv = v_cnt_q;
    end
  end

  // Test pattern for the current pixel using the mode latched for this frame.
  always_comb begin
    pattern = 8'h00;
    case (mode_q)
      2'd0:    pattern = h_cnt_q[7:0];
      2'd1:    pattern = v_cnt_q[7:0];
      2'd2:    pattern = (h_cnt_q[5] ^ v_cnt_q[5]) ? 8'hFF : 8'h00;
      default: pattern = flat_level;
    endcase
  end

  // Run/drain state machine, counter sequencing and per-frame mode capture.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        h_cnt_d = 12'd0;
        v_cnt_d = 12'd0;
        if (en) begin
          state_d = ST_RUN;
          mode_d  = mode;
        end
      end
      ST_RUN: begin
        h_cnt_d = h_adv;
        v_cnt_d = v_adv;
        // Dropping en on the very last clock of a frame stops right there,
        // otherwise DRAIN would walk through a whole extra frame.
        if (!en) begin
          state_d = frame_last ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        h_cnt_d = h_adv;
        v_cnt_d = v_adv;
        if (en) begin
          state_d = ST_RUN;
        end else if (frame_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        h_cnt_d = 12'd0;
        v_cnt_d = 12'd0;
      end
    endcase
    // The mode for the next frame is captured as the counters return to the
    // origin, so a mid-frame change never tears the frame being drawn.
    if (running && frame_last) begin
      mode_d = mode;
    end
  end

  // Registered stream outputs and frame bookkeeping, one clock behind counters.
  always_comb begin
    de_d         = running && de_c;
    data_d       = de_d ? pattern : 8'h00;
    hsync_d      = (running && hs_c) ? SYNC_POL : ~SYNC_POL;
    vsync_d      = (running && vs_c) ? SYNC_POL : ~SYNC_POL;
    // Counters sitting one past the last active pixel mean the output edge
    // now occurring is the one where Y_de drops after that pixel.
    frame_done_d = running && (h_cnt_q == H_DISP) && (v_cnt_q == V_DISP_END);
    frame_cnt_d  = frame_done_d ? (frame_cnt_q + 16'd1) : frame_cnt_q;
  end

  // State, counter and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      h_cnt_q      <= 12'd0;
      v_cnt_q      <= 12'd0;
      mode_q       <= 2'd0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      de_q         <= 1'b0;
      data_q       <= 8'h00;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      mode_q       <= mode_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign y_out.Y_hsync = hsync_q;
  assign y_out.Y_vsync = vsync_q;
  assign y_out.Y_de    = de_q;
  assign y_out.Y_data  = data_q;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_y_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_y_pattern_gen
// Description : Self-checking bench for y_pattern_gen with a reduced raster
//               so that several whole frames fit in a short run. Expected
//               stream values come from a linear pixel-position model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y_pattern_gen;

  localparam int HD = 48, HF = 4, HS = 6, HB = 5;
  localparam int VD = 40, VF = 3, VS = 2, VB = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic SP = 1'b0;
  localparam logic [27:0] RST_V = {~SP, ~SP, 1'b0, 8'h00, 1'b0, 16'h0000};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic [1:0]  mode  = 2'd0;
  logic [7:0]  flat  = 8'h00;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: position within the frame, latched mode, counters.
  bit          m_on    = 1'b0;
  int          m_cnt   = 0;
  logic [1:0]  m_mode  = 2'd0;
  logic [15:0] m_fcnt  = 16'h0000;
  int          m_frame = 0;
  logic [27:0] exp_v;
  int          sh_x, sh_y, sh_frame;

  y_pattern_gen_if yif ();

  y_pattern_gen #(
    .H_DISP(12'(HD)), .H_FRONT(12'(HF)), .H_SYNC(12'(HS)), .H_BACK(12'(HB)),
    .V_DISP(12'(VD)), .V_FRONT(12'(VF)), .V_SYNC(12'(VS)), .V_BACK(12'(VB)),
    .SYNC_POL(SP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .flat_level (flat),
    .y_out      (yif),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] observed();
    return {yif.Y_hsync, yif.Y_vsync, yif.Y_de, yif.Y_data, frame_done, frame_cnt};
  endfunction

  // Predict what the coming clock edge shows, then move to the next falling edge.
  task automatic advance();
    int x, y;
    logic de, hs, vs, fd;
    logic [7:0] d;
    if (!m_on) begin
      exp_v = {~SP, ~SP, 1'b0, 8'h00, 1'b0, m_fcnt};
      sh_x = -1; sh_y = -1; sh_frame = -1;
      if (en) begin
        m_on = 1'b1; m_cnt = 0; m_mode = mode;
      end
    end else begin
      x  = m_cnt % HT;
      y  = m_cnt / HT;
      de = (x < HD) && (y < VD);
      hs = (x >= HD + HF) && (x < HD + HF + HS);
      vs = (y >= VD + VF) && (y < VD + VF + VS);
      case (m_mode)
        2'd0:    d = 8'(x % 256);
        2'd1:    d = 8'(y % 256);
        2'd2:    d = ((((x / 32) + (y / 32)) % 2) == 1) ? 8'hFF : 8'h00;
        default: d = flat;
      endcase
      if (!de) d = 8'h00;
      fd = (x == HD) && (y == VD - 1);
      if (fd) m_fcnt = m_fcnt + 16'd1;
      exp_v = {(hs ? SP : ~SP), (vs ? SP : ~SP), de, d, fd, m_fcnt};
      sh_x = x; sh_y = y; sh_frame = m_frame;
      if (m_cnt == FRAME - 1) begin
        m_cnt = 0; m_frame++; m_mode = mode;
        if (!en) m_on = 1'b0;
      end else begin
        m_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; flat = 8'h00;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (observed() !== RST_V) begin
      n_err++; $display("FAIL reset_values: got %h want %h", observed(), RST_V);
    end
    rst_n = 1'b1;
    m_on = 1'b0; m_fcnt = 16'h0000; m_mode = 2'd0; m_frame = 0;
    for (int i = 0; i < 4; i++) begin
      mode = 2'($urandom); flat = 8'($urandom);
      advance();
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++; $display("FAIL reset_idle cycle %0d: got %h want %h", i, observed(), exp_v);
      end
    end
  endtask

  task automatic test_hramp_timing();
    int first_de, de_fall, de_rise2, hs_fall, hs_rise, vs_fall, vs_rise, fd1, fd2;
    logic prev_de, prev_hs, prev_vs;
    bit done;
    first_de = -1; de_fall = -1; de_rise2 = -1; hs_fall = -1; hs_rise = -1;
    vs_fall = -1; vs_rise = -1; fd1 = -1; fd2 = -1;
    prev_de = 1'b0; prev_hs = ~SP; prev_vs = ~SP; done = 1'b0;
    en = 1'b1; mode = 2'd0;
    for (int k = 1; k <= 2 * FRAME + 4 * HT && !done; k++) begin
      advance();
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++; $display("FAIL hramp k=%0d pix(%0d,%0d): got %h want %h", k, sh_x, sh_y, observed(), exp_v);
      end
      if (yif.Y_de && first_de < 0) first_de = k;
      if (!yif.Y_de && prev_de && de_fall < 0) de_fall = k;
      if (yif.Y_de && !prev_de && de_fall >= 0 && de_rise2 < 0) de_rise2 = k;
      if (yif.Y_hsync == SP && prev_hs != SP && hs_fall < 0) hs_fall = k;
      if (yif.Y_hsync != SP && prev_hs == SP && hs_fall >= 0 && hs_rise < 0) hs_rise = k;
      if (yif.Y_vsync == SP && prev_vs != SP && vs_fall < 0) vs_fall = k;
      if (yif.Y_vsync != SP && prev_vs == SP && vs_fall >= 0 && vs_rise < 0) vs_rise = k;
      if (frame_done) begin
        if (fd1 < 0) fd1 = k;
        else if (fd2 < 0) begin fd2 = k; en = 1'b0; end
      end
      prev_de = yif.Y_de; prev_hs = yif.Y_hsync; prev_vs = yif.Y_vsync;
      if (!en && !m_on) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL hramp_timeout: got running want idle"); end
    n_cmp++;
    if (first_de != 2) begin n_err++; $display("FAIL first_de_latency: got %0d want 2", first_de); end
    n_cmp++;
    if (hs_fall - de_fall != HF) begin n_err++; $display("FAIL hsync_offset: got %0d want %0d", hs_fall - de_fall, HF); end
    n_cmp++;
    if (hs_rise - hs_fall != HS) begin n_err++; $display("FAIL hsync_width: got %0d want %0d", hs_rise - hs_fall, HS); end
    n_cmp++;
    if (de_rise2 - de_fall != HT - HD) begin n_err++; $display("FAIL de_blank: got %0d want %0d", de_rise2 - de_fall, HT - HD); end
    n_cmp++;
    if (vs_rise - vs_fall != VS * HT) begin n_err++; $display("FAIL vsync_width: got %0d want %0d", vs_rise - vs_fall, VS * HT); end
    n_cmp++;
    if (fd2 - fd1 != FRAME) begin n_err++; $display("FAIL frame_period: got %0d want %0d", fd2 - fd1, FRAME); end
  endtask

  task automatic test_checker_switch();
    int f0, hits;
    bit done;
    hits = 0; done = 1'b0;
    en = 1'b1; mode = 2'd2; f0 = m_frame;
    for (int k = 1; k <= 2 * FRAME + 4 * HT && !done; k++) begin
      advance();
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++; $display("FAIL checker k=%0d pix(%0d,%0d): got %h want %h", k, sh_x, sh_y, observed(), exp_v);
      end
      if (sh_frame == f0 && sh_x == 0 && sh_y == 20) mode = 2'd1;
      if (sh_frame == f0 && ((sh_x == 32 && sh_y == 0) || (sh_x == 0 && sh_y == 32) || (sh_x == 32 && sh_y == 30))) begin
        hits++; n_cmp++;
        if (yif.Y_data !== 8'hFF) begin n_err++; $display("FAIL checker_white (%0d,%0d): got %h want ff", sh_x, sh_y, yif.Y_data); end
      end
      if (sh_frame == f0 && sh_x == 32 && sh_y == 32) begin
        hits++; n_cmp++;
        if (yif.Y_data !== 8'h00) begin n_err++; $display("FAIL checker_black: got %h want 00", yif.Y_data); end
      end
      if (sh_frame == f0 + 1 && sh_x == 10 && sh_y == 5) begin
        hits++; n_cmp++; en = 1'b0;
        if (yif.Y_data !== 8'h05) begin n_err++; $display("FAIL vramp_next_frame: got %h want 05", yif.Y_data); end
      end
      if (!en && !m_on) done = 1'b1;
    end
    n_cmp++;
    if (!done || hits != 5) begin
      n_err++; $display("FAIL checker_coverage: got done=%0d hits=%0d want done=1 hits=5", done, hits);
    end
  endtask

  task automatic test_drain_idle();
    int f0, pulses, idle_run;
    logic [15:0] c0;
    bit done;
    pulses = 0; idle_run = 0; done = 1'b0;
    en = 1'b1; mode = 2'd3; f0 = m_frame; c0 = frame_cnt;
    for (int k = 1; k <= FRAME + 400 && !done; k++) begin
      flat = 8'($urandom);
      advance();
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++; $display("FAIL drain k=%0d pix(%0d,%0d): got %h want %h", k, sh_x, sh_y, observed(), exp_v);
      end
      if (sh_frame == f0 && sh_x == 0 && sh_y == 10) en = 1'b0;
      if (frame_done) pulses++;
      if (!en && !m_on) begin
        mode = 2'($urandom);
        idle_run++;
        if (idle_run >= 200) done = 1'b1;
      end
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL drain_timeout: got running want idle"); end
    n_cmp++;
    if (pulses != 1) begin n_err++; $display("FAIL drain_pulses: got %0d want 1", pulses); end
    n_cmp++;
    if (16'(frame_cnt - c0) !== 16'd1) begin n_err++; $display("FAIL drain_count: got +%0d want +1", 16'(frame_cnt - c0)); end
    n_cmp++;
    if ({yif.Y_hsync, yif.Y_vsync, yif.Y_de, yif.Y_data} !== {~SP, ~SP, 1'b0, 8'h00}) begin
      n_err++; $display("FAIL idle_outputs: got %b%b%b %h want %b%b0 00", yif.Y_hsync, yif.Y_vsync, yif.Y_de, yif.Y_data, ~SP, ~SP);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    int fd_t[$];
    logic [15:0] c0;
    bit done;
    done = 1'b0;
    en = 1'b1; mode = 2'($urandom); f0 = m_frame; c0 = frame_cnt;
    for (int k = 1; k <= 3 * FRAME + 4 * HT && !done; k++) begin
      flat = 8'($urandom);
      advance();
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++; $display("FAIL b2b k=%0d pix(%0d,%0d): got %h want %h", k, sh_x, sh_y, observed(), exp_v);
      end
      if (sh_frame == f0 && sh_x == 0 && sh_y == 10) en = 1'b0;
      if (sh_frame == f0 && sh_x == 0 && sh_y == 30) en = 1'b1;
      if (sh_frame == f0 + 1 && sh_x == 7 && sh_y == 15) en = 1'b0;
      if (sh_frame == f0 + 1 && sh_x == 40 && sh_y == 15) en = 1'b1;
      if (sh_x == 0 && sh_y == 20) mode = 2'($urandom);
      if (frame_done) begin
        fd_t.push_back(k);
        if (fd_t.size() == 3) en = 1'b0;
      end
      if (fd_t.size() >= 3 && !m_on) done = 1'b1;
    end
    n_cmp++;
    if (!done || fd_t.size() != 3) begin
      n_err++; $display("FAIL b2b_pulses: got %0d done=%0d want 3 done=1", fd_t.size(), done);
    end else begin
      n_cmp++;
      if (fd_t[1] - fd_t[0] != FRAME || fd_t[2] - fd_t[1] != FRAME) begin
        n_err++; $display("FAIL b2b_period: got %0d,%0d want %0d", fd_t[1] - fd_t[0], fd_t[2] - fd_t[1], FRAME);
      end
    end
    n_cmp++;
    if (16'(frame_cnt - c0) !== 16'd3) begin n_err++; $display("FAIL b2b_count: got +%0d want +3", 16'(frame_cnt - c0)); end
  endtask

  task automatic test_async_reset();
    bit hit, done, forced, wrapped;
    hit = 1'b0; done = 1'b0; forced = 1'b0; wrapped = 1'b0;
    en = 1'b1; mode = 2'd0;
    for (int k = 1; k <= FRAME && !hit; k++) begin
      advance();
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++; $display("FAIL pre_reset k=%0d: got %h want %h", k, observed(), exp_v);
      end
      if (sh_x == 30 && sh_y == 20) hit = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (!hit || observed() !== RST_V) begin
      n_err++; $display("FAIL async_clear hit=%0d: got %h want %h", hit, observed(), RST_V);
    end
    m_on = 1'b0; m_fcnt = 16'h0000; m_mode = 2'd0;
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; mode = 2'd0;
    for (int k = 1; k <= FRAME + 4 * HT && !done; k++) begin
      advance();
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++; $display("FAIL restart k=%0d pix(%0d,%0d): got %h want %h", k, sh_x, sh_y, observed(), exp_v);
      end
      if (k == 2) begin
        n_cmp++;
        if ({yif.Y_de, yif.Y_data} !== 9'h100 || sh_x != 0 || sh_y != 0) begin
          n_err++; $display("FAIL restart_origin: got de=%b data=%h want de=1 data=00 at (0,0)", yif.Y_de, yif.Y_data);
        end
      end
      if (sh_x == 0 && sh_y == 2) begin
        force dut.frame_cnt_q = 16'hFFFF;
        #1 release dut.frame_cnt_q;
        m_fcnt = 16'hFFFF; forced = 1'b1;
        n_cmp++;
        if (frame_cnt !== 16'hFFFF) begin n_err++; $display("FAIL preload: got %h want ffff", frame_cnt); end
      end
      if (frame_done) begin
        wrapped = 1'b1; en = 1'b0;
        n_cmp++;
        if (frame_cnt !== 16'h0000) begin n_err++; $display("FAIL cnt_wrap: got %h want 0000", frame_cnt); end
      end
      if (!en && !m_on) done = 1'b1;
    end
    n_cmp++;
    if (!done || !forced || !wrapped) begin
      n_err++; $display("FAIL wrap_sequence: got done=%0d forced=%0d wrapped=%0d want 1 1 1", done, forced, wrapped);
    end
  endtask

  initial begin
    test_reset();
    test_hramp_timing();
    test_checker_switch();
    test_drain_idle();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
